// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } ctrl_state_t;

  // Width of one scoreboard counter able to hold 0..max_inflight.
  function automatic int sb_cnt_w(input int max_inflight);
    return (max_inflight < 1) ? 1 : $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/EX/WB sideband seen by the hazard controller and the
// pipeline-register controls it returns.
interface hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic                 id_valid_inst;
  logic                 id_reg_wr;
  logic [REG_IDX_W-1:0] id_dest_idx;
  logic [REG_IDX_W-1:0] id_ra_idx;
  logic [REG_IDX_W-1:0] id_rb_idx;
  logic                 id_uses_ra;
  logic                 id_uses_rb;
  logic                 id_illegal;
  logic                 id_halt;
  logic                 ex_take_branch;
  logic                 wb_valid;
  logic                 wb_reg_wr;
  logic [REG_IDX_W-1:0] wb_dest_idx;

  logic                 if_stall;
  logic                 id_bubble;
  logic                 if_id_flush;
  logic                 halted;
  logic [31:0]          stall_cnt;
  logic [31:0]          flush_cnt;

  // Pipeline side: presents stage information, consumes controls.
  modport master (
    output id_valid_inst, id_reg_wr, id_dest_idx, id_ra_idx, id_rb_idx,
           id_uses_ra, id_uses_rb, id_illegal, id_halt, ex_take_branch,
           wb_valid, wb_reg_wr, wb_dest_idx,
    input  if_stall, id_bubble, if_id_flush, halted, stall_cnt, flush_cnt
  );

  // Controller side.
  modport slave (
    input  id_valid_inst, id_reg_wr, id_dest_idx, id_ra_idx, id_rb_idx,
           id_uses_ra, id_uses_rb, id_illegal, id_halt, ex_take_branch,
           wb_valid, wb_reg_wr, wb_dest_idx,
    output if_stall, id_bubble, if_id_flush, halted, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_scoreboard.sv
// Per-register count of in-flight writes between ID issue and WB retire,
// with two busy lookups for the decode read ports.
module reg_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter int WB_BYPASS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,          // active-low, asynchronous
  input  logic                 issue,
  input  logic [REG_IDX_W-1:0] issue_idx,
  input  logic                 retire,
  input  logic [REG_IDX_W-1:0] retire_idx,
  input  logic [REG_IDX_W-1:0] ra_idx,
  input  logic [REG_IDX_W-1:0] rb_idx,
  output logic                 ra_busy,
  output logic                 rb_busy,
  output logic                 all_clear
);

  localparam int CW = sb_cnt_w(MAX_INFLIGHT);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt     [NUM_REGS];
  logic [CW-1:0] cnt_nxt [NUM_REGS];

  // A register still in flight unless its last write retires right now
  // and the regfile forwards that write.
  function automatic logic busy_f(input logic [CW-1:0] c, input logic hit);
    return (c != '0) && !((WB_BYPASS != 0) && (c == CNT_ONE) && hit);
  endfunction

  // Issue/retire update; simultaneous hit on one register cancels,
  // out-of-range moves saturate instead of wrapping.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_nxt[r] = cnt[r];
      if (REG_IDX_W'(r) == ZERO_REG) begin
        cnt_nxt[r] = '0;
      end else if (issue && (issue_idx == REG_IDX_W'(r)) &&
                   !(retire && (retire_idx == REG_IDX_W'(r)))) begin
        if (cnt[r] != CNT_MAX) cnt_nxt[r] = cnt[r] + CNT_ONE;
      end else if (retire && (retire_idx == REG_IDX_W'(r)) &&
                   !(issue && (issue_idx == REG_IDX_W'(r)))) begin
        if (cnt[r] != '0) cnt_nxt[r] = cnt[r] - CNT_ONE;
      end
    end
  end

  // Empty once this cycle's retire has been applied.
  always_comb begin
    all_clear = 1'b1;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (cnt_nxt[r] != '0) all_clear = 1'b0;
    end
  end

  assign ra_busy = busy_f(cnt[ra_idx], retire && (retire_idx == ra_idx));
  assign rb_busy = busy_f(cnt[rb_idx], retire && (retire_idx == rb_idx));

  // Counter storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_nxt[r];
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage sequencing: RAW stalls, branch squash, halt drain.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter int BR_PENALTY   = 1,
  parameter int WB_BYPASS    = 1
) (
  input  logic         clk,
  input  logic         rst,          // active-low, asynchronous
  hazard_ctrl_if.slave bus
);

  localparam int FW = (BR_PENALTY < 1) ? 1 : $clog2(BR_PENALTY + 1);

  ctrl_state_t   state, state_nxt;
  logic [FW-1:0] fl_cnt, fl_cnt_nxt;
  logic [31:0]   stall_cnt, flush_cnt;
  logic          stall_inc, flush_inc;
  logic          if_stall, id_bubble, if_id_flush, halted;
  logic          issue, retire, ra_busy, rb_busy, all_clear, hazard;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign issue  = bus.id_valid_inst && bus.id_reg_wr &&
                  (bus.id_dest_idx != ZERO_REG) && !id_bubble;
  assign retire = bus.wb_valid && bus.wb_reg_wr && (bus.wb_dest_idx != ZERO_REG);

  reg_scoreboard #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .WB_BYPASS    (WB_BYPASS)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .issue_idx  (bus.id_dest_idx),
    .retire     (retire),
    .retire_idx (bus.wb_dest_idx),
    .ra_idx     (bus.id_ra_idx),
    .rb_idx     (bus.id_rb_idx),
    .ra_busy    (ra_busy),
    .rb_busy    (rb_busy),
    .all_clear  (all_clear)
  );

  assign hazard = bus.id_valid_inst &&
                  ((bus.id_uses_ra && (bus.id_ra_idx != ZERO_REG) && ra_busy) ||
                   (bus.id_uses_rb && (bus.id_rb_idx != ZERO_REG) && rb_busy));

  // Next state and same-cycle pipeline controls; branch beats halt beats hazard.
  always_comb begin
    state_nxt   = state;
    fl_cnt_nxt  = fl_cnt;
    if_stall    = 1'b0;
    id_bubble   = 1'b0;
    if_id_flush = 1'b0;
    halted      = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    case (state)
      RUN: begin
        if (bus.ex_take_branch) begin
          if_id_flush = 1'b1;
          id_bubble   = 1'b1;
          flush_inc   = 1'b1;
          if (BR_PENALTY > 0) begin
            state_nxt  = FLUSH;
            fl_cnt_nxt = FW'(BR_PENALTY);
          end
        end else if (bus.id_valid_inst && (bus.id_illegal || bus.id_halt)) begin
          if_stall  = 1'b1;
          id_bubble = 1'b1;
          state_nxt = DRAIN;
        end else if (hazard) begin
          if_stall  = 1'b1;
          id_bubble = 1'b1;
          stall_inc = 1'b1;
        end
      end
      FLUSH: begin
        if_id_flush = 1'b1;
        id_bubble   = 1'b1;
        if (fl_cnt <= FW'(1)) begin
          state_nxt  = RUN;
          fl_cnt_nxt = '0;
        end else begin
          fl_cnt_nxt = fl_cnt - FW'(1);
        end
      end
      DRAIN: begin
        if_stall  = 1'b1;
        id_bubble = 1'b1;
        if (all_clear) state_nxt = HALTED;
      end
      HALTED: begin
        halted    = 1'b1;
        if_stall  = 1'b1;
        id_bubble = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
    // Controls read as idle for the whole time reset is held.
    if (!rst) begin
      if_stall    = 1'b0;
      id_bubble   = 1'b0;
      if_id_flush = 1'b0;
      halted      = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
    end
  end

  // State, squash down-counter and saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      fl_cnt    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= state_nxt;
      fl_cnt <= fl_cnt_nxt;
      if (stall_inc) stall_cnt <= sat_inc(stall_cnt);
      if (flush_inc) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign bus.if_stall    = if_stall;
  assign bus.id_bubble   = id_bubble;
  assign bus.if_id_flush = if_id_flush;
  assign bus.halted      = halted;
  assign bus.stall_cnt   = stall_cnt;
  assign bus.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, hand sequences for halt
// drain and reset, then random traffic against a behavioural model.
module tb_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int MAX_INFLIGHT = 3;
  localparam int BR_PENALTY   = 1;
  localparam int WB_BYPASS    = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hif();

  hazard_ctrl #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .BR_PENALTY   (BR_PENALTY),
    .WB_BYPASS    (WB_BYPASS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       valid, wr;
    logic [4:0] dest, ra, rb;
    logic       ua, ub, ill, hlt, br, wbv;
    logic [4:0] wbd;
    logic       e_stall, e_bub, e_flush;
  } vec_t;

  function automatic vec_t mk(input int valid, wr, dest, ua, ra, ub, rb,
                              ill, hlt, br, wbv, wbd, es, eb, ef);
    vec_t v;
    v.valid = 1'(valid); v.wr = 1'(wr); v.dest = 5'(dest);
    v.ua = 1'(ua); v.ra = 5'(ra); v.ub = 1'(ub); v.rb = 5'(rb);
    v.ill = 1'(ill); v.hlt = 1'(hlt); v.br = 1'(br);
    v.wbv = 1'(wbv); v.wbd = 5'(wbd);
    v.e_stall = 1'(es); v.e_bub = 1'(eb); v.e_flush = 1'(ef);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    hif.id_valid_inst  = v.valid;
    hif.id_reg_wr      = v.wr;
    hif.id_dest_idx    = v.dest;
    hif.id_ra_idx      = v.ra;
    hif.id_rb_idx      = v.rb;
    hif.id_uses_ra     = v.ua;
    hif.id_uses_rb     = v.ub;
    hif.id_illegal     = v.ill;
    hif.id_halt        = v.hlt;
    hif.ex_take_branch = v.br;
    hif.wb_valid       = v.wbv;
    hif.wb_reg_wr      = v.wbv;
    hif.wb_dest_idx    = v.wbd;
  endtask

  // Inputs applied 1 time unit after a rising edge, outputs sampled 2 later,
  // then the cycle is closed on the next rising edge.
  task automatic cyc(input string name, input vec_t v);
    drive(v);
    #2;
    chk({name, "_stall"}, 32'(hif.if_stall),    32'(v.e_stall));
    chk({name, "_bub"},   32'(hif.id_bubble),   32'(v.e_bub));
    chk({name, "_flush"}, 32'(hif.if_id_flush), 32'(v.e_flush));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- behavioural reference ----------------
  int         m_cnt [32];
  bit         m_halted, m_drain;
  int         m_fl;
  logic [31:0] m_stall, m_flush;
  int         q[$];

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_halted = 0; m_drain = 0; m_fl = 0;
    m_stall = 0; m_flush = 0;
    q.delete();
  endtask

  function automatic bit m_busy(input int r, input bit ret, input int wd);
    return (m_cnt[r] != 0) && !(WB_BYPASS != 0 && m_cnt[r] == 1 && ret && wd == r);
  endfunction

  vec_t tbl[13];

  initial begin
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    rst = 1'b0;
    #12;
    chk("rst_stall",  32'(hif.if_stall),    32'd0);
    chk("rst_bub",    32'(hif.id_bubble),   32'd0);
    chk("rst_halted", 32'(hif.halted),      32'd0);
    chk("rst_scnt",   hif.stall_cnt,        32'd0);
    chk("rst_fcnt",   hif.flush_cnt,        32'd0);
    chk("rst_state",  32'(dut.state),       32'(RUN));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Directed table: back-to-back RAW, x0 sources, x7 cancel, branch over stall.
    tbl[0]  = mk(1,1,5, 0,0, 0,0, 0,0,0, 0,0, 0,0,0);
    tbl[1]  = mk(1,0,0, 1,5, 0,0, 0,0,0, 0,0, 1,1,0);
    tbl[2]  = mk(1,0,0, 1,5, 0,0, 0,0,0, 0,0, 1,1,0);
    tbl[3]  = mk(1,0,0, 1,5, 0,0, 0,0,0, 1,5, 0,0,0);
    tbl[4]  = mk(1,1,0, 1,0, 0,0, 0,0,0, 0,0, 0,0,0);
    tbl[5]  = mk(1,0,0, 1,0, 1,0, 0,0,0, 1,0, 0,0,0);
    tbl[6]  = mk(1,1,7, 0,0, 0,0, 0,0,0, 0,0, 0,0,0);
    tbl[7]  = mk(1,1,7, 0,0, 0,0, 0,0,0, 1,7, 0,0,0);
    tbl[8]  = mk(1,0,0, 0,0, 1,7, 0,0,0, 0,0, 1,1,0);
    tbl[9]  = mk(1,0,0, 0,0, 1,7, 0,0,1, 0,0, 0,1,1);
    tbl[10] = mk(1,0,0, 0,0, 1,7, 0,0,0, 0,0, 0,1,1);
    tbl[11] = mk(1,0,0, 0,0, 1,7, 0,0,0, 1,7, 0,0,0);
    tbl[12] = mk(0,0,0, 0,0, 0,0, 0,0,0, 0,0, 0,0,0);
    for (int i = 0; i < 13; i++) begin
      cyc($sformatf("tbl%0d", i), tbl[i]);
      if (i == 0)  chk("cnt5_issued", 32'(dut.u_sb.cnt[5]), 32'd1);
      if (i == 3)  begin
        chk("raw_scnt", hif.stall_cnt, 32'd2);
        chk("cnt5_retired", 32'(dut.u_sb.cnt[5]), 32'd0);
      end
      if (i == 5)  chk("cnt0_zero", 32'(dut.u_sb.cnt[0]), 32'd0);
      if (i == 7)  chk("cnt7_cancel", 32'(dut.u_sb.cnt[7]), 32'd1);
      if (i == 9)  begin
        chk("br_fcnt", hif.flush_cnt, 32'd1);
        chk("br_scnt", hif.stall_cnt, 32'd3);
      end
      if (i == 10) chk("flush_scnt", hif.stall_cnt, 32'd3);
    end

    // Halt with three writes in flight; branch during drain is ignored.
    cyc("h_i1", mk(1,1,1, 0,0,0,0, 0,0,0, 0,0, 0,0,0));
    cyc("h_i2", mk(1,1,2, 0,0,0,0, 0,0,0, 0,0, 0,0,0));
    cyc("h_i3", mk(1,1,3, 0,0,0,0, 0,0,0, 0,0, 0,0,0));
    cyc("h_halt", mk(1,0,0, 0,0,0,0, 0,1,0, 0,0, 1,1,0));
    chk("h_state_drain", 32'(dut.state), 32'(DRAIN));
    cyc("h_br", mk(1,0,0, 0,0,0,0, 0,1,1, 0,0, 1,1,0));
    chk("h_br_fcnt", hif.flush_cnt, 32'd1);
    cyc("h_r1", mk(0,0,0, 0,0,0,0, 0,0,0, 1,1, 1,1,0));
    cyc("h_r2", mk(0,0,0, 0,0,0,0, 0,0,0, 1,2, 1,1,0));
    chk("h_not_halted", 32'(hif.halted), 32'd0);
    cyc("h_r3", mk(0,0,0, 0,0,0,0, 0,0,0, 1,3, 1,1,0));
    chk("h_halted", 32'(hif.halted), 32'd1);
    cyc("h_idle", mk(1,1,4, 0,0,0,0, 0,0,1, 0,0, 1,1,0));
    chk("h_halted_hold", 32'(hif.halted), 32'd1);

    // Reset asserted in the middle of a drain.
    do_reset();
    cyc("d_i4", mk(1,1,4, 0,0,0,0, 0,0,0, 0,0, 0,0,0));
    cyc("d_halt", mk(1,0,0, 1,4,0,0, 0,1,0, 0,0, 1,1,0));
    drive(mk(1,1,6, 1,4,0,0, 0,1,1, 0,0, 0,0,0));
    #1;
    rst = 1'b0;
    #1;
    chk("d_rst_stall",  32'(hif.if_stall),    32'd0);
    chk("d_rst_bub",    32'(hif.id_bubble),   32'd0);
    chk("d_rst_flush",  32'(hif.if_id_flush), 32'd0);
    chk("d_rst_halted", 32'(hif.halted),      32'd0);
    chk("d_rst_state",  32'(dut.state),       32'(RUN));
    chk("d_rst_cnt4",   32'(dut.u_sb.cnt[4]), 32'd0);
    chk("d_rst_scnt",   hif.stall_cnt,        32'd0);
    chk("d_rst_fcnt",   hif.flush_cnt,        32'd0);
    drive(mk(0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0,0));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    cyc("d_i9",  mk(1,1,9, 0,0,0,0, 0,0,0, 0,0, 0,0,0));
    cyc("d_c9",  mk(1,0,0, 1,9,0,0, 0,0,0, 0,0, 1,1,0));
    chk("d_c9_scnt", hif.stall_cnt, 32'd1);

    // Random traffic against the model.
    do_reset();
    model_reset();
    begin
      int halt_cycles = 0;
      for (int n = 0; n < 4000; n++) begin
        vec_t v;
        bit ret, haz, es, eb, ef, eh, iss, was_drain, clear;
        int d, wd;
        v = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        v.valid = ($urandom % 4) != 0;
        v.wr    = 1'($urandom % 2);
        d       = int'($urandom % 8);
        v.dest  = 5'(d);
        if (d != 0 && m_cnt[d] >= MAX_INFLIGHT) v.wr = 1'b0;
        v.ua  = 1'($urandom % 2);
        v.ub  = 1'($urandom % 2);
        v.ra  = 5'($urandom % 8);
        v.rb  = 5'($urandom % 8);
        v.ill = ($urandom % 300) == 0;
        v.hlt = ($urandom % 300) == 0;
        v.br  = ($urandom % 8) == 0;
        drive(v);
        wd = 0;
        ret = 0;
        if (q.size() > 0 && ($urandom % 3) != 0) begin
          wd = q[0];
          hif.wb_valid    = 1'b1;
          hif.wb_reg_wr   = ($urandom % 8) != 0;
          hif.wb_dest_idx = 5'(wd);
          ret = hif.wb_reg_wr;
        end else if (($urandom % 16) == 0) begin
          hif.wb_valid    = 1'b1;
          hif.wb_reg_wr   = 1'b1;
          hif.wb_dest_idx = 5'd0;
        end

        haz = v.valid && ((v.ua && v.ra != 0 && m_busy(int'(v.ra), ret, wd)) ||
                          (v.ub && v.rb != 0 && m_busy(int'(v.rb), ret, wd)));
        es = 0; eb = 0; ef = 0; eh = 0;
        was_drain = m_drain;
        if (m_halted) begin
          es = 1; eb = 1; eh = 1;
        end else if (m_drain) begin
          es = 1; eb = 1;
        end else if (m_fl > 0) begin
          ef = 1; eb = 1; m_fl--;
        end else if (v.br) begin
          ef = 1; eb = 1; m_flush++; m_fl = BR_PENALTY;
        end else if (v.valid && (v.ill || v.hlt)) begin
          es = 1; eb = 1; m_drain = 1;
        end else if (haz) begin
          es = 1; eb = 1; m_stall++;
        end
        iss = v.valid && v.wr && d != 0 && !eb;

        #2;
        chk("rnd_stall",  32'(hif.if_stall),    32'(es));
        chk("rnd_bub",    32'(hif.id_bubble),   32'(eb));
        chk("rnd_flush",  32'(hif.if_id_flush), 32'(ef));
        chk("rnd_halted", 32'(hif.halted),      32'(eh));
        @(posedge clk); #1;

        if (iss) begin m_cnt[d]++; q.push_back(d); end
        if (ret) begin m_cnt[wd]--; void'(q.pop_front()); end
        if (iss && m_cnt[d] > MAX_INFLIGHT) begin
          errors++;
          $display("FAIL sb_overflow reg=%0d count=%0d limit=%0d", d, m_cnt[d], MAX_INFLIGHT);
        end
        if (ret && m_cnt[wd] < 0) begin
          errors++;
          $display("FAIL sb_underflow reg=%0d count=%0d", wd, m_cnt[wd]);
        end
        clear = (q.size() == 0);
        if (was_drain && clear) begin m_drain = 0; m_halted = 1; end

        chk("rnd_scnt", hif.stall_cnt, m_stall);
        chk("rnd_fcnt", hif.flush_cnt, m_flush);
        begin
          int bad = -1;
          for (int r = 0; r < 32; r++)
            if (int'(dut.u_sb.cnt[r]) != m_cnt[r] && bad < 0) bad = r;
          chk("rnd_sb_first_bad_reg", 32'(bad), 32'hFFFF_FFFF);
        end

        if (m_halted) halt_cycles++;
        if (halt_cycles > 3) begin
          halt_cycles = 0;
          do_reset();
          model_reset();
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
